paddle_renderer: RTL and testbench

PADDLE_RENDERER -- requirements
Module: paddle_renderer

---
 rtl/paddle_pkg.sv | 30 +++
 rtl/paddle_span_calc.sv | 65 ++++++
 rtl/paddle_renderer.sv | 158 +++++++++++++++
 tb/tb_paddle_renderer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle renderer.
//   paddle_state_t    : frame sequencer states (IDLE, DRAW, DONE)
//   DEFAULT_PAD_COLOR : default paddle colour
//   DEFAULT_BG_COLOR  : default erase colour
//   pixel_color()     : colour of a column given the latched paddle left edge
package paddle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } paddle_state_t;

  localparam logic [2:0] DEFAULT_PAD_COLOR = 3'b001;
  localparam logic [2:0] DEFAULT_BG_COLOR  = 3'b000;

  // Paddle colour inside [left, left+pad_w), erase colour elsewhere.
  function automatic logic [2:0] pixel_color(input logic [7:0] col,
                                             input logic [7:0] left,
                                             input int         pad_w,
                                             input logic [2:0] on_color,
                                             input logic [2:0] off_color);
    int c;
    int l;
    c = int'(col);
    l = int'(left);
    return ((c >= l) && (c < l + pad_w)) ? on_color : off_color;
  endfunction

endpackage

// File: rtl/paddle_span_calc.sv
// Combinational paddle placement and scan-window computation.
//   position   : requested paddle centre x (0..511)
//   prev_left  : left edge drawn by the previous completed frame
//   prev_valid : prev_left holds a real previous frame
//   left       : clamp(position - PAD_W/2, 0, SCREEN_W-PAD_W)
//   first_col  : first column to scan this frame
//   last_col   : last column to scan this frame
// Optional feature: define PADDLE_DIRTY_RECT_EN to restrict the scan to the
// union of the old and new paddle footprints once a previous frame exists.
module paddle_span_calc #(
  parameter int SCREEN_W = 160,
  parameter int PAD_W    = 7
) (
  input  logic [8:0] position,
  input  logic [7:0] prev_left,
  input  logic       prev_valid,
  output logic [7:0] left,
  output logic [7:0] first_col,
  output logic [7:0] last_col
);

`ifdef PADDLE_DIRTY_RECT_EN
  localparam bit DIRTY_EN = 1'b1;
`else
  localparam bit DIRTY_EN = 1'b0;
`endif

  localparam logic signed [10:0] HALF_W   = 11'(PAD_W / 2);
  localparam logic signed [10:0] MAX_LEFT = 11'(SCREEN_W - PAD_W);

  logic signed [10:0] raw_left;
  logic        [7:0]  lo_col;
  logic        [7:0]  hi_left;

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first) so no latch is inferred.
    left      = '0;
    first_col = '0;
    last_col  = 8'(SCREEN_W - 1);
    lo_col    = '0;
    hi_left   = '0;

    // Widened signed subtraction so a centre near 0 goes negative instead
    // of wrapping to a large column.
    raw_left = $signed({2'b00, position}) - HALF_W;
    if (raw_left[10])
      left = '0;
    else if (raw_left > MAX_LEFT)
      left = MAX_LEFT[7:0];
    else
      left = raw_left[7:0];

    lo_col  = (prev_left < left) ? prev_left : left;
    hi_left = (prev_left > left) ? prev_left : left;

    // The union always contains the new paddle, so it is never empty; the
    // sum stays within SCREEN_W-1 because both edges are clamped.
    if (DIRTY_EN && prev_valid) begin
      first_col = lo_col;
      last_col  = hi_left + 8'(PAD_W - 1);
    end
  end

endmodule

// File: rtl/paddle_renderer.sv
// Paddle renderer: on start, scans a column-major rectangle of pixels on rows
// PAD_Y..PAD_Y+PAD_H-1, painting PAD_COLOR over the paddle and BG_COLOR
// elsewhere, with downstream back-pressure via stall.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : one-cycle frame request, honoured only in IDLE
//   position     : paddle centre x, sampled when start is accepted
//   stall        : holds the current pixel (x, y, color, plot)
//   busy         : frame in progress (DRAW or DONE)
//   plot         : x/y/color carry a valid pixel
//   done         : one-cycle end-of-frame pulse
//   x, y, color  : pixel coordinates and colour
// Optional feature: define PADDLE_DIRTY_RECT_EN to scan only the columns
// touched by the old and new paddle after the first completed frame.
module paddle_renderer
  import paddle_pkg::*;
#(
  parameter int         SCREEN_W  = 160,
  parameter int         PAD_W     = 7,
  parameter int         PAD_H     = 3,
  parameter int         PAD_Y     = 112,
  parameter logic [2:0] PAD_COLOR = DEFAULT_PAD_COLOR,
  parameter logic [2:0] BG_COLOR  = DEFAULT_BG_COLOR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] position,
  input  logic       stall,
  output logic       busy,
  output logic       plot,
  output logic       done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] color
);

  localparam logic [6:0] FIRST_ROW = 7'(PAD_Y);
  localparam logic [6:0] LAST_ROW  = 7'(PAD_Y + PAD_H - 1);

  paddle_state_t state_q, state_d;

  logic [7:0] left_q;
  logic [7:0] last_col_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] color_q;
  logic [7:0] prev_left_q;
  logic       prev_valid_q;

  logic [7:0] span_left;
  logic [7:0] span_first;
  logic [7:0] span_last;

  logic take_start;
  logic accept;
  logic last_pixel;

  paddle_span_calc #(
    .SCREEN_W (SCREEN_W),
    .PAD_W    (PAD_W)
  ) u_span (
    .position   (position),
    .prev_left  (prev_left_q),
    .prev_valid (prev_valid_q),
    .left       (span_left),
    .first_col  (span_first),
    .last_col   (span_last)
  );

  assign last_pixel = (x_q == last_col_q) && (y_q == LAST_ROW);

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    plot       = 1'b0;
    done       = 1'b0;
    take_start = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          take_start = 1'b1;
          state_d    = DRAW;
        end
      end
      DRAW: begin
        busy = 1'b1;
        plot = 1'b1;
        if (!stall) begin
          accept = 1'b1;
          if (last_pixel)
            state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel walker and frame bookkeeping.
  always_ff @(posedge clock) begin
    // NOTE: every register here is reset explicitly; there is no storage
    // array, so a full reset costs nothing and makes an aborted frame
    // indistinguishable from power-up.
    if (reset) begin
      left_q       <= '0;
      last_col_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
      prev_left_q  <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      if (take_start) begin
        left_q     <= span_left;
        last_col_q <= span_last;
        x_q        <= span_first;
        y_q        <= FIRST_ROW;
        color_q    <= pixel_color(span_first, span_left, PAD_W, PAD_COLOR, BG_COLOR);
      end else if (accept && !last_pixel) begin
        if (y_q == LAST_ROW) begin
          // Colour only changes at a column boundary.
          y_q     <= FIRST_ROW;
          x_q     <= x_q + 8'd1;
          color_q <= pixel_color(x_q + 8'd1, left_q, PAD_W, PAD_COLOR, BG_COLOR);
        end else begin
          y_q <= y_q + 7'd1;
        end
      end
      // After the final pixel x/y/color keep showing it.

      if (state_q == DONE) begin
        prev_left_q  <= left_q;
        prev_valid_q <= 1'b1;
      end
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign color = color_q;

endmodule

// File: tb/tb_paddle_renderer.sv
// Self-checking bench for paddle_renderer. A frame-level model builds the
// expected pixel list from position (clamp, scan window, colour rule) and is
// compared against every DUT output on every cycle; per-frame measurements are
// also pinned to hand-computed literals. Honours PADDLE_DIRTY_RECT_EN.
module tb_paddle_renderer;

  localparam int SCREEN_W = 160;
  localparam int PAD_W    = 7;
  localparam int PAD_H    = 3;
  localparam int PAD_Y    = 112;
  localparam int PAD_C    = 1;
  localparam int BG_C     = 0;

`ifdef PADDLE_DIRTY_RECT_EN
  localparam bit DIRTY = 1'b1;
`else
  localparam bit DIRTY = 1'b0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_DRAW = 1;
  localparam int P_DONE = 2;

  logic       clock;
  logic       reset;
  logic       start;
  logic [8:0] position;
  logic       stall;
  logic       busy;
  logic       plot;
  logic       done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;

  paddle_renderer #(
    .SCREEN_W  (SCREEN_W),
    .PAD_W     (PAD_W),
    .PAD_H     (PAD_H),
    .PAD_Y     (PAD_Y),
    .PAD_COLOR (3'b001),
    .BG_COLOR  (3'b000)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .position (position),
    .stall    (stall),
    .busy     (busy),
    .plot     (plot),
    .done     (done),
    .x        (x),
    .y        (y),
    .color    (color)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct {
    int px;
    int py;
    int pc;
  } pix_t;

  pix_t exp_q[$];
  pix_t cur;
  int   m_phase      = P_IDLE;
  int   m_left       = 0;
  int   m_prev_left  = 0;
  bit   m_prev_valid = 1'b0;

  task automatic build_frame(input int pos);
    int l;
    int lo;
    int hi;
    pix_t p;
    l = pos - PAD_W / 2;
    if (l < 0) l = 0;
    if (l > SCREEN_W - PAD_W) l = SCREEN_W - PAD_W;
    lo = 0;
    hi = SCREEN_W - 1;
    if (DIRTY && m_prev_valid) begin
      lo = (l < m_prev_left) ? l : m_prev_left;
      hi = ((l > m_prev_left) ? l : m_prev_left) + PAD_W - 1;
    end
    exp_q.delete();
    for (int c = lo; c <= hi; c++) begin
      for (int r = PAD_Y; r < PAD_Y + PAD_H; r++) begin
        p.px = c;
        p.py = r;
        p.pc = (c >= l && c < l + PAD_W) ? PAD_C : BG_C;
        exp_q.push_back(p);
      end
    end
    m_left = l;
  endtask

  task automatic model_step(input bit s_reset, input bit s_start,
                            input bit s_stall, input int s_pos);
    if (s_reset) begin
      exp_q.delete();
      m_phase      = P_IDLE;
      m_left       = 0;
      m_prev_left  = 0;
      m_prev_valid = 1'b0;
      cur          = '{0, 0, 0};
    end else begin
      case (m_phase)
        P_IDLE: if (s_start) begin
          build_frame(s_pos);
          m_phase = P_DRAW;
          cur     = exp_q[0];
        end
        P_DRAW: if (!s_stall) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_phase = P_DONE;
          else cur = exp_q[0];
        end
        default: begin
          m_phase      = P_IDLE;
          m_prev_left  = m_left;
          m_prev_valid = 1'b1;
        end
      endcase
    end
  endtask

  // Advance one clock, update the model with the inputs sampled at that
  // edge, then compare every output 1 time unit later.
  task automatic tick();
    bit s_reset;
    bit s_start;
    bit s_stall;
    int s_pos;
    s_reset = reset;
    s_start = start;
    s_stall = stall;
    s_pos   = int'(position);
    @(posedge clock);
    model_step(s_reset, s_start, s_stall, s_pos);
    #1;
    cyc++;
    check("busy",  busy,  (m_phase != P_IDLE) ? 1 : 0);
    check("plot",  plot,  (m_phase == P_DRAW) ? 1 : 0);
    check("done",  done,  (m_phase == P_DONE) ? 1 : 0);
    check("x",     x,     cur.px);
    check("y",     y,     cur.py);
    check("color", color, cur.pc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Runs one frame; measures accepted pixels, done cycle (start cycle = 0),
  // painted column range and done count, optionally poking start while busy.
  task automatic run_frame(input int pos, input int st_at, input int st_len,
                           input bit poke, input int exp_pix, input int exp_done,
                           input int exp_lo, input int exp_hi);
    int rel;
    int acc;
    int done_rel;
    int dones;
    int lo;
    int hi;
    int painted;
    acc = 0; done_rel = -1; dones = 0; lo = 999; hi = -1; painted = 0;
    position = 9'(pos);
    start    = 1'b1;
    stall    = 1'b0;
    tick();
    start = 1'b0;
    rel   = 1;
    while (rel < 1200) begin
      if (done) begin
        done_rel = rel;
        dones++;
        break;
      end
      stall = (rel >= st_at) && (rel < st_at + st_len);
      start = poke && (rel == 10);
      if (start) position = 9'd0;
      if (plot && !stall) begin
        acc++;
        if (color == 3'(PAD_C)) begin
          painted++;
          if (int'(x) < lo) lo = int'(x);
          if (int'(x) > hi) hi = int'(x);
        end
      end
      tick();
      rel++;
    end
    // Leave the DONE cycle, with a start request that must be ignored.
    stall    = 1'b0;
    start    = poke;
    position = 9'd0;
    tick();
    start = 1'b0;
    repeat (4) begin
      if (done) dones++;
      tick();
    end
    check("frame_pixels", acc, exp_pix);
    check("done_cycle",   done_rel, exp_done);
    check("done_count",   dones, 1);
    check("paddle_lo",    lo, exp_lo);
    check("paddle_hi",    hi, exp_hi);
    check("paddle_px",    painted, PAD_W * PAD_H);
  endtask

  initial begin
    int acc;
    int guard;
    int dones;
    reset    = 1'b1;
    start    = 1'b0;
    stall    = 1'b0;
    position = 9'd0;

    do_reset();
    check("rst_busy",  busy,  0);
    check("rst_plot",  plot,  0);
    check("rst_x",     x,     0);
    check("rst_color", color, 0);

    // Basic frame, then moves that exercise clamping and the dirty window.
    run_frame(50, 0, 0, 1'b0, 480, 481, 47, 53);
    run_frame(63, 0, 0, 1'b0, DIRTY ? 60 : 480, DIRTY ? 61 : 481, 60, 66);
    run_frame(0, 0, 0, 1'b0, DIRTY ? 201 : 480, DIRTY ? 202 : 481, 0, 6);
    run_frame(300, 0, 0, 1'b0, 480, 481, 153, 159);

    // Five stall cycles mid-frame delay done by five.
    do_reset();
    run_frame(50, 200, 5, 1'b0, 480, 486, 47, 53);

    // Starts while busy are dropped; a later start still works.
    do_reset();
    run_frame(50, 0, 0, 1'b1, 480, 481, 47, 53);
    check("idle_after_poke", busy, 0);
    run_frame(50, 0, 0, 1'b0, DIRTY ? 21 : 480, DIRTY ? 22 : 481, 47, 53);

    // Reset at pixel 100 aborts the frame and forgets the previous paddle.
    do_reset();
    run_frame(50, 0, 0, 1'b0, 480, 481, 47, 53);
    position = 9'd100;
    start    = 1'b1;
    tick();
    start = 1'b0;
    acc   = 0;
    guard = 0;
    while (acc < 100 && guard < 1000) begin
      if (plot) acc++;
      tick();
      guard++;
    end
    check("abort_reached", acc, 100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_plot",  plot,  0);
    check("abort_busy",  busy,  0);
    check("abort_done",  done,  0);
    check("abort_x",     x,     0);
    check("abort_y",     y,     0);
    check("abort_color", color, 0);
    dones = 0;
    repeat (10) begin
      tick();
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_frame(63, 0, 0, 1'b0, 480, 481, 60, 66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
